// File: rtl/chess_pkg.sv
// Shared chess core types: piece encoding, square addressing and the
// back-rank layout used whenever the board is reset to the opening position.
package chess_pkg;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6,
    PT_RSVD   = 3'd7
  } piece_type_t;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef logic [5:0] square_t;

  typedef struct packed {
    logic        color;
    piece_type_t ptype;
  } piece_t;

  localparam int SQUARES = 64;

  function automatic piece_type_t back_rank_type(input logic [2:0] col);
    piece_type_t t;
    case (col)
      3'd0:    t = PT_ROOK;
      3'd1:    t = PT_KNIGHT;
      3'd2:    t = PT_BISHOP;
      3'd3:    t = PT_QUEEN;
      3'd4:    t = PT_KING;
      3'd5:    t = PT_BISHOP;
      3'd6:    t = PT_KNIGHT;
      3'd7:    t = PT_ROOK;
      default: t = PT_EMPTY;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/board_init_rom.sv
// Combinational opening-position lookup: square in, piece out.
module board_init_rom
  import chess_pkg::*;
(
  input  square_t square_i,
  output piece_t  piece_o
);

  logic [2:0] row_s;
  logic [2:0] col_s;

  assign row_s = square_i[5:3];
  assign col_s = square_i[2:0];

  // Row 0 / 7 hold the back ranks, rows 1 / 6 the pawns, everything else empty.
  always_comb begin
    piece_o.color = COLOR_WHITE;
    piece_o.ptype = PT_EMPTY;
    case (row_s)
      3'd0: begin
        piece_o.color = COLOR_WHITE;
        piece_o.ptype = back_rank_type(col_s);
      end
      3'd1: begin
        piece_o.color = COLOR_WHITE;
        piece_o.ptype = PT_PAWN;
      end
      3'd6: begin
        piece_o.color = COLOR_BLACK;
        piece_o.ptype = PT_PAWN;
      end
      3'd7: begin
        piece_o.color = COLOR_BLACK;
        piece_o.ptype = back_rank_type(col_s);
      end
      default: begin
        piece_o.color = COLOR_WHITE;
        piece_o.ptype = PT_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/board_arbiter.sv
// Owner of the board RAM port: loads the opening position, then arbitrates
// between the video renderer (fixed priority) and game logic (starvation-guarded).
module board_arbiter
  import chess_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              new_game,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] IDX_LAST   = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              game_rvalid_q, game_rvalid_d;
  logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
  logic              init_done_q, init_done_d;
  piece_t            init_piece_s;

  board_init_rom u_init_rom (
    .square_i (square_t'(idx_q)),
    .piece_o  (init_piece_s)
  );

  // Grant selection and RAM port mux; the starvation override beats video.
  always_comb begin
    vid_gnt   = 1'b0;
    game_gnt  = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_addr  = idx_q;
      ram_wdata = DATA_W'(init_piece_s);
    end else begin
      if (game_req && (starve_cnt_q == STARVE_MAX)) begin
        game_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end else if (game_req) begin
        game_gnt = 1'b1;
      end else begin
        game_gnt = 1'b0;
      end
      if (game_gnt) begin
        ram_addr  = game_addr;
        ram_we    = game_we;
        ram_wdata = game_wdata;
      end else if (vid_gnt) begin
        ram_addr  = vid_addr;
        ram_we    = 1'b0;
      end else begin
        ram_we    = 1'b0;
      end
    end
  end

  // Next-state, init counter, starvation counter and read-response bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (new_game) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase

    if (game_req && !game_gnt) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else begin
      starve_cnt_d = '0;
    end

    vid_rvalid_d  = vid_gnt;
    game_rvalid_d = game_gnt & ~game_we;
    init_done_d   = (state_d == ST_RUN);

    if (vid_rvalid_q || game_rvalid_q) begin
      rdata_hold_d = ram_rdata;
    end else begin
      rdata_hold_d = rdata_hold_q;
    end
  end

  // State and response registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_INIT;
      idx_q         <= '0;
      starve_cnt_q  <= '0;
      vid_rvalid_q  <= 1'b0;
      game_rvalid_q <= 1'b0;
      rdata_hold_q  <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      starve_cnt_q  <= starve_cnt_d;
      vid_rvalid_q  <= vid_rvalid_d;
      game_rvalid_q <= game_rvalid_d;
      rdata_hold_q  <= rdata_hold_d;
      init_done_q   <= init_done_d;
    end
  end

  // RAM data is only valid in the response cycle; otherwise show the last response.
  always_comb begin
    if (vid_rvalid_q || game_rvalid_q) begin
      rdata = ram_rdata;
    end else begin
      rdata = rdata_hold_q;
    end
  end

  assign vid_rvalid  = vid_rvalid_q;
  assign game_rvalid = game_rvalid_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_board_arbiter.sv
// Directed bench for board_arbiter with a behavioural 1-cycle-read board RAM.
module tb_board_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       vid_req;
  logic [5:0] vid_addr;
  logic       vid_gnt;
  logic       vid_rvalid;
  logic       game_req;
  logic       game_we;
  logic [5:0] game_addr;
  logic [3:0] game_wdata;
  logic       game_gnt;
  logic       game_rvalid;
  logic [3:0] rdata;
  logic       init_done;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  logic [3:0] mem [0:63];
  logic [5:0] exp_idx;
  int         wr_cnt;
  int         order_err;
  int         checks;
  int         errors;

  board_arbiter dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .new_game    (new_game),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_gnt     (vid_gnt),
    .vid_rvalid  (vid_rvalid),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_addr   (game_addr),
    .game_wdata  (game_wdata),
    .game_gnt    (game_gnt),
    .game_rvalid (game_rvalid),
    .rdata       (rdata),
    .init_done   (init_done),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    ram_rdata = 4'h0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Tracks the init sweep: every INIT write must hit the next square in order.
  always @(posedge clk) begin
    if (reset) begin
      exp_idx <= 6'd0;
    end else if (ram_we && !init_done) begin
      if (ram_addr != exp_idx) order_err <= order_err + 1;
      exp_idx <= exp_idx + 6'd1;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge of the first INIT cycle; returns cycles until init_done.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  int k;
  int wr_snap;

  initial begin
    checks = 0; errors = 0; wr_cnt = 0; order_err = 0;
    reset = 1'b1; new_game = 1'b0;
    vid_req = 1'b0; vid_addr = 6'd0;
    game_req = 1'b0; game_we = 1'b0; game_addr = 6'd0; game_wdata = 4'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_init_done", {31'd0, init_done}, 32'd0);
    check_eq("rst_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check_eq("rst_game_rvalid", {31'd0, game_rvalid}, 32'd0);
    check_eq("rst_rdata", {28'd0, rdata}, 32'd0);

    // Initial load
    @(posedge clk); #1;
    reset = 1'b0;
    wr_snap = wr_cnt;
    @(negedge clk);
    check_eq("init_first_addr", {26'd0, ram_addr}, 32'd0);
    check_eq("init_gnt", {30'd0, vid_gnt, game_gnt}, 32'd0);
    wait_init(n);
    check_eq("init_cycles", n, 64);
    check_eq("init_writes", wr_cnt - wr_snap, 64);
    check_eq("init_order", order_err, 0);
    check_eq("ram4_wking", {28'd0, mem[4]}, 32'h6);
    check_eq("ram60_bking", {28'd0, mem[60]}, 32'hE);
    check_eq("ram9_wpawn", {28'd0, mem[9]}, 32'h1);
    check_eq("ram27_empty", {28'd0, mem[27]}, 32'h0);

    // Video read of square 3
    tick(); vid_req = 1'b1; vid_addr = 6'd3;
    @(negedge clk);
    check_eq("vid_gnt", {31'd0, vid_gnt}, 32'd1);
    tick(); vid_req = 1'b0;
    @(negedge clk);
    check_eq("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
    check_eq("vid_rdata_q", {28'd0, rdata}, 32'h5);
    check_eq("vid_no_game_rvalid", {31'd0, game_rvalid}, 32'd0);

    // Game read starved by continuous video
    tick(); vid_req = 1'b1; vid_addr = 6'd0;
    game_req = 1'b1; game_we = 1'b0; game_addr = 6'd48;
    k = 1;
    @(negedge clk);
    check_eq("starve_vid_first", {31'd0, vid_gnt}, 32'd1);
    while (!game_gnt && k < 10) begin
      tick(); k++;
      @(negedge clk);
    end
    check_eq("starve_wait", k, 5);
    check_eq("starve_vid_blocked", {31'd0, vid_gnt}, 32'd0);
    tick(); game_req = 1'b0;
    @(negedge clk);
    check_eq("starve_game_rvalid", {31'd0, game_rvalid}, 32'd1);
    check_eq("starve_rdata", {28'd0, rdata}, 32'h9);
    check_eq("starve_vid_back", {31'd0, vid_gnt}, 32'd1);
    tick(); vid_req = 1'b0;

    // Game write, then video read-back
    tick(); game_req = 1'b1; game_we = 1'b1; game_addr = 6'd36; game_wdata = 4'h2;
    @(negedge clk);
    check_eq("wr_gnt", {31'd0, game_gnt}, 32'd1);
    tick(); game_req = 1'b0; game_we = 1'b0;
    @(negedge clk);
    check_eq("wr_no_rvalid", {30'd0, game_rvalid, vid_rvalid}, 32'd0);
    tick(); vid_req = 1'b1; vid_addr = 6'd36;
    @(negedge clk);
    tick(); vid_req = 1'b0;
    @(negedge clk);
    check_eq("rb_rvalid", {31'd0, vid_rvalid}, 32'd1);
    check_eq("rb_rdata", {28'd0, rdata}, 32'h2);
    tick();
    @(negedge clk);
    check_eq("rdata_hold", {28'd0, rdata}, 32'h2);

    // new_game coinciding with a video grant
    tick(); vid_req = 1'b1; vid_addr = 6'd4; new_game = 1'b1;
    @(negedge clk);
    check_eq("ng_vid_gnt", {31'd0, vid_gnt}, 32'd1);
    wr_snap = wr_cnt;
    tick(); vid_req = 1'b0; new_game = 1'b0;
    @(negedge clk);
    check_eq("ng_vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
    check_eq("ng_rdata", {28'd0, rdata}, 32'h6);
    check_eq("ng_init_done_low", {31'd0, init_done}, 32'd0);
    wait_init(n);
    check_eq("ng_init_cycles", n, 64);
    check_eq("ng_writes", wr_cnt - wr_snap, 64);
    check_eq("ng_ram36", {28'd0, mem[36]}, 32'h0);

    // Reset while a game read response is pending
    tick(); game_req = 1'b1; game_we = 1'b0; game_addr = 6'd60;
    @(negedge clk);
    check_eq("rst_game_gnt", {31'd0, game_gnt}, 32'd1);
    reset = 1'b1; game_req = 1'b0;
    @(negedge clk);
    check_eq("rst_rvalid_killed", {31'd0, game_rvalid}, 32'd0);
    check_eq("rst_init_drop", {31'd0, init_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_snap = wr_cnt;
    @(negedge clk);
    check_eq("rst_restart_addr", {26'd0, ram_addr}, 32'd0);
    wait_init(n);
    check_eq("rst_init_cycles", n, 64);
    check_eq("rst_writes", wr_cnt - wr_snap, 64);
    check_eq("rst_order", order_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_arbiter.md
# board_arbiter

Sole owner of the chess core's 64-square board RAM (single-port, 1-cycle synchronous read). It loads the standard starting position after reset or on request. It then shares the RAM port between two requesters: the VGA renderer (read-only, latency-critical) and the game logic (read/write). Video has fixed priority, and a starvation guard bounds how long the game requester can wait.

## Interface
- ADDR_W, 6, square address {row[2:0], col[2:0]}; row 0 = white back rank
- DATA_W, 4, piece code {color, type[2:0]}
- STARVE_LIMIT, 4, consecutive denied game cycles before game overrides video
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- new_game  in  1  one-cycle pulse; reload starting position
- vid_req  in  1  renderer read request
- vid_addr  in  ADDR_W  renderer square address
- vid_gnt  out  1  renderer request accepted this cycle
- vid_rvalid  out  1  rdata belongs to renderer
- game_req  in  1  game logic request
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game square address
- game_wdata  in  DATA_W  write data
- game_gnt  out  1  game request accepted this cycle
- game_rvalid  out  1  rdata belongs to game (reads only)
- rdata  out  DATA_W  shared read data
- init_done  out  1  high in RUN
- ram_addr / ram_we / ram_wdata  out  ADDR_W / 1 / DATA_W  RAM port
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after address presented

## Operation
- Piece types: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved. Color bit: 0 white, 1 black.
- Starting position:
  - row 0: R N B Q K B N R (white), col 0..7
  - row 1: white pawns
  - row 6: black pawns
  - row 7: black R N B Q K B N R
  - all other squares 0
- FSM has two states, INIT and RUN.
- INIT:
  - Counter idx runs 0..63.
  - Each cycle drives ram_we=1, ram_addr=idx, ram_wdata=start(idx).
  - All gnt are 0. init_done=0.
  - After idx=63 is written, go to RUN.
- RUN, grant selection (combinational, same cycle as request):
  - If game_req and starve_cnt==STARVE_LIMIT, grant game.
  - Otherwise, if vid_req, grant video.
  - Otherwise, if game_req, grant game.
  - Otherwise, no grant; ram_we=0.
- ram_addr, ram_we and ram_wdata mux from the granted requester. A video grant forces ram_we=0.
- Requesters hold req, addr, we and wdata stable until they see gnt.
- starve_cnt:
  - Increments when game_req=1 and game_gnt=0, saturating at STARVE_LIMIT.
  - Clears on game_gnt or when game_req=0.
- Read response: the cycle after a granted read, exactly one of vid_rvalid / game_rvalid is 1, and rdata = ram_rdata. A game write produces no rvalid.
- new_game in RUN:
  - The current cycle's grant still completes, including its rvalid next cycle.
  - Next state is INIT with idx=0.
  - new_game during INIT is ignored.

## Timing
- Reset values:
  - state=INIT, idx=0, starve_cnt=0
  - vid_rvalid=0, game_rvalid=0, rdata=0, init_done=0, all gnt=0
  - RAM write of square 0 begins the first cycle after reset deasserts.
- INIT takes 64 cycles. init_done rises 64 cycles after reset deasserts.
- Grant-to-rvalid latency is 1 cycle. Back-to-back grants give back-to-back rvalids.
- Worst-case game wait under continuous video requests is STARVE_LIMIT+1 cycles from first request to grant.
- Reset mid-operation aborts everything: a pending rvalid is suppressed, and INIT restarts from idx 0.
- rdata holds its last value when no rvalid is asserted.

## Structure
- The shared package chess_pkg holds:
  - piece_type_t enum
  - color bit constant
  - square_t (6-bit)
  - the piece_t packed struct
- Sub-module board_init_rom: combinational, square_t in, piece_t out. It encodes the starting position and is reused by any future board-reset logic.
- All remaining FSM, counter and mux logic is in board_arbiter.

## Test plan
- Reset deasserts, RAM model monitored:
  - 64 writes occur, idx 0..63.
  - RAM[4]=0x6 (white king), RAM[60]=0xE (black king), RAM[9]=0x1, RAM[27]=0x0.
  - init_done rises on cycle 64.
- RUN, vid_req only, vid_addr=3:
  - vid_gnt is 1 the same cycle.
  - Next cycle vid_rvalid=1, rdata=0x5.
- vid_req held high every cycle plus game_req read of addr 48:
  - game_gnt asserts on the 5th cycle of game_req (STARVE_LIMIT=4).
  - game_rvalid=1 next cycle with rdata=0x9.
  - vid_gnt=0 in that cycle only.
- Game write 0x2 to addr 36 with no video, then video read of 36:
  - game_rvalid stays 0 after the write.
  - Video read returns 0x2.
- new_game pulsed in the same cycle as a granted video read:
  - vid_rvalid is still delivered next cycle.
  - init_done drops, and a 64-cycle INIT follows.
  - RAM[36] is restored to 0x0.
- Reset asserted the cycle after a game read grant:
  - game_rvalid stays 0.
  - INIT restarts at idx 0.
